// File: rtl/binary_step_counter_4_bits.sv
// 4-bit up/down counter feeding the binary-to-BCD display stage.
// Q advances on a prescaled tick or on a synchronized pushbutton edge; Load and Reset override both.
module binary_step_counter_4_bits #(
  parameter int DIV   = 50000000,
  parameter int DIV_W = 26
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       En,
  input  logic       Up,
  input  logic       Load,
  input  logic [3:0] D,
  input  logic       Step,
  output logic [3:0] Q,
  output logic       Wrap,
  output logic       Tick
);

  localparam logic [DIV_W-1:0] P_LAST = DIV_W'(DIV - 1);

  logic [DIV_W-1:0] p_q, p_d;
  logic [3:0]       q_q, q_d;
  logic             wrap_q, wrap_d;
  logic             tick_q, tick_d;
  logic             s1_q, s2_q, s3_q;
  logic             tk, st, adv;

  // s1/s2 resolve metastability on the raw button; s3 delays s2 so a held press yields one edge.
  assign st  = s2_q & ~s3_q;
  assign tk  = En && (p_q == P_LAST);
  assign adv = tk | st;

  // NOTE: every always_comb output gets a default first so no path through the
  // if/else leaves it unassigned, which would infer a latch.
  always_comb begin
    p_d    = p_q;
    q_d    = q_q;
    wrap_d = 1'b0;
    tick_d = 1'b0;
    if (Load) begin
      q_d = D;
      p_d = '0;
    end else begin
      // Disabling clears the prescaler so re-enabling always starts a full period.
      if (!En || tk) p_d = '0;
      else           p_d = p_q + 1'b1;
      tick_d = tk;
      if (adv) begin
        if (Up) begin
          q_d    = q_q + 4'd1;
          wrap_d = (q_q == 4'd15);
        end else begin
          q_d    = q_q - 4'd1;
          wrap_d = (q_q == 4'd0);
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      p_q    <= '0;
      q_q    <= '0;
      wrap_q <= 1'b0;
      tick_q <= 1'b0;
      // Reset high on the synchronizer means a button held through reset is not a new press.
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      s3_q   <= 1'b1;
    end else begin
      p_q    <= p_d;
      q_q    <= q_d;
      wrap_q <= wrap_d;
      tick_q <= tick_d;
      s1_q   <= Step;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
    end
  end

  assign Q    = q_q;
  assign Wrap = wrap_q;
  assign Tick = tick_q;

endmodule

// File: tb/tb_binary_step_counter_4_bits.sv
// Scoreboard bench for binary_step_counter_4_bits with DIV=4: the stimulus process queues
// cycle-tagged expected outputs, and a monitor compares them on the falling edge.
module tb_binary_step_counter_4_bits;

  logic       clk = 1'b0;
  logic       rst, en, up, load, step;
  logic [3:0] d;
  logic [3:0] q;
  logic       wrap, tick;

  binary_step_counter_4_bits #(.DIV(4), .DIV_W(3)) dut (
    .Clock(clk), .Reset(rst), .En(en), .Up(up), .Load(load), .D(d),
    .Step(step), .Q(q), .Wrap(wrap), .Tick(tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [3:0] q;
    logic       wrap;
    logic       tick;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int c, input logic [3:0] eq, input logic ew,
                      input logic et, input string nm);
    exp_t e;
    e.cyc = c; e.q = eq; e.wrap = ew; e.tick = et; e.name = nm;
    exp_q.push_back(e);
  endtask

  task automatic go(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: compares whatever expectation is due in the current cycle.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (e.cyc < cyc) begin
        failures++;
        $display("FAIL %s: expectation for cycle %0d not reached in time (now %0d)",
                 e.name, e.cyc, cyc);
      end else if (q !== e.q || wrap !== e.wrap || tick !== e.tick) begin
        failures++;
        $display("FAIL %s @cyc %0d: got Q=%0d Wrap=%b Tick=%b, want Q=%0d Wrap=%b Tick=%b",
                 e.name, cyc, q, wrap, tick, e.q, e.wrap, e.tick);
      end
    end
  end

  initial begin
    int r, c, l, m, a, b;
    rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; step = 1'b0; d = 4'd0;

    // Test 1: reset, then count up with wrap at the 16th advance.
    go(2);
    r = cyc;
    push(r, 4'd0, 1'b0, 1'b0, "reset_state");
    rst = 1'b0; en = 1'b1; up = 1'b1;
    push(r + 1, 4'd0, 1'b0, 1'b0, "t1_no_early_tick");
    push(r + 3, 4'd0, 1'b0, 1'b0, "t1_before_first");
    for (int k = 1; k <= 16; k++)
      push(r + 4 * k, 4'(k % 16), (k == 16), 1'b1, "t1_advance");
    push(r + 65, 4'd0, 1'b0, 1'b0, "t1_wrap_one_cycle");
    go(r + 65);

    // Test 2: load 5, then load 9 mid-period; next advance 4 cycles after the load edge.
    c = cyc;
    load = 1'b1; d = 4'd5;
    push(c + 1, 4'd5, 1'b0, 1'b0, "t2_load5");
    go(c + 1);
    load = 1'b0;
    push(c + 3, 4'd5, 1'b0, 1'b0, "t2_hold5");
    go(c + 3);
    load = 1'b1; d = 4'd9;
    push(c + 4, 4'd9, 1'b0, 1'b0, "t2_load9");
    go(c + 4);
    load = 1'b0;
    push(c + 7, 4'd9, 1'b0, 1'b0, "t2_no_early_adv");
    push(c + 8, 4'd10, 1'b0, 1'b1, "t2_adv_after_load");
    go(c + 8);

    // Test 3: count down from 0 wraps to 15, then 14 without wrap.
    l = cyc + 1;
    load = 1'b1; d = 4'd0; up = 1'b0;
    push(l, 4'd0, 1'b0, 1'b0, "t3_load0");
    go(l);
    load = 1'b0;
    push(l + 4, 4'd15, 1'b1, 1'b1, "t3_down_wrap");
    push(l + 5, 4'd15, 1'b0, 1'b0, "t3_wrap_clear");
    push(l + 8, 4'd14, 1'b0, 1'b1, "t3_down_14");
    go(l + 8);

    // Test 4: held pushbutton steps once; release and press again steps once more.
    m = cyc + 1;
    en = 1'b0; up = 1'b1; load = 1'b1; d = 4'd5;
    push(m, 4'd5, 1'b0, 1'b0, "t4_load5");
    go(m);
    load = 1'b0; step = 1'b1;
    push(m + 2, 4'd5, 1'b0, 1'b0, "t4_sync_latency");
    push(m + 3, 4'd6, 1'b0, 1'b0, "t4_step_k2");
    push(m + 10, 4'd6, 1'b0, 1'b0, "t4_held_single");
    go(m + 10);
    step = 1'b0;
    go(m + 13);
    step = 1'b1;
    push(m + 15, 4'd6, 1'b0, 1'b0, "t4_second_latency");
    push(m + 16, 4'd7, 1'b0, 1'b0, "t4_second_step");
    go(m + 16);
    step = 1'b0;

    // Test 5: step edge coincident with tick gives one increment; then Load beats both.
    a = cyc + 1;
    en = 1'b1; load = 1'b1; d = 4'd3;
    push(a, 4'd3, 1'b0, 1'b0, "t5_load3");
    go(a);
    load = 1'b0;
    go(a + 1);
    step = 1'b1;
    push(a + 3, 4'd3, 1'b0, 1'b0, "t5_before_coinc");
    push(a + 4, 4'd4, 1'b0, 1'b1, "t5_coinc_single");
    go(a + 4);
    step = 1'b0;
    push(a + 8, 4'd5, 1'b0, 1'b1, "t5_plain_tick");
    go(a + 9);
    step = 1'b1;
    go(a + 11);
    load = 1'b1; d = 4'd12;
    push(a + 12, 4'd12, 1'b0, 1'b0, "t5_load_wins");
    go(a + 12);
    load = 1'b0;
    push(a + 13, 4'd12, 1'b0, 1'b0, "t5_step_discarded");
    push(a + 16, 4'd13, 1'b0, 1'b1, "t5_period_restart");
    go(a + 16);

    // Test 6: reset with the button held high; no step until released and pressed again.
    b = cyc;
    en = 1'b0; load = 1'b1; d = 4'd7;
    push(b + 1, 4'd7, 1'b0, 1'b0, "t6_load7");
    go(b + 1);
    load = 1'b0; rst = 1'b1;
    push(b + 2, 4'd0, 1'b0, 1'b0, "t6_reset_clears");
    go(b + 2);
    rst = 1'b0;
    push(b + 5, 4'd0, 1'b0, 1'b0, "t6_held_no_step");
    push(b + 8, 4'd0, 1'b0, 1'b0, "t6_still_zero");
    go(b + 8);
    step = 1'b0;
    go(b + 11);
    step = 1'b1;
    push(b + 13, 4'd0, 1'b0, 1'b0, "t6_press_latency");
    push(b + 14, 4'd1, 1'b0, 1'b0, "t6_press_step");
    go(b + 14);
    step = 1'b0;
    push(b + 16, 4'd1, 1'b0, 1'b0, "t6_hold");
    go(b + 17);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      failures += exp_q.size();
      $display("FAIL drain: %0d expectations never compared, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
